// File: rtl/inst_fetch_pkg.sv
// Shared pipeline definitions for the fetch and execute stages: fetch FSM
// encoding, instruction size and branch/jump bus field layout.
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam int unsigned INST_BYTES    = 32'd4;
  localparam int unsigned BJ_TARGET_LSB = 32'd0;

  // The taken flag sits directly above the BITS-wide target field.
  function automatic int unsigned bj_taken_bit(input int unsigned bits);
    return bits;
  endfunction

endpackage

// File: rtl/inst_fetch_out_reg.sv
// Decode-facing output register: holds one fetched instruction and its PC
// until decode consumes it or a redirect flushes it.
module fetch_out_reg #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            load,
  input  logic            flush,
  input  logic            consume,
  input  logic [BITS-1:0] pc_in,
  input  logic [BITS-1:0] inst_in,
  output logic            valid,
  output logic [BITS-1:0] pc,
  output logic [BITS-1:0] inst
);

  // Flush outranks load so a redirect never lets a stale word through.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid <= 1'b0;
      pc    <= '0;
      inst  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= pc_in;
      inst  <= inst_in;
    end else if (consume) begin
      valid <= 1'b0;
    end else begin
      valid <= valid;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, fetch FSM and redirect handling,
// feeding decode through fetch_out_reg.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int            BITS     = 32,
  parameter logic [BITS-1:0] RESET_PC = {BITS{1'b0}}
) (
  input  logic            Clk,
  input  logic            Rstn,
  input  logic [BITS:0]   BjBus,
  output logic            ImemReq,
  output logic [BITS-1:0] ImemAddr,
  input  logic            ImemAck,
  input  logic [BITS-1:0] ImemData,
  output logic            DecValid,
  output logic [BITS-1:0] DecPC,
  output logic [BITS-1:0] DecInst,
  input  logic            DecReady
);

  localparam int unsigned TAKEN_BIT = bj_taken_bit(BITS);

  fetch_state_e    state_r, state_next_s;
  logic [BITS-1:0] pc_r, pc_next_s;
  logic [BITS-1:0] tgt_r, tgt_next_s;
  logic            req_r, req_next_s;
  logic            load_s, flush_s, consume_s;
  logic            bj_taken_s;
  logic [BITS-1:0] bj_target_s;
  logic [BITS-1:0] pc_inc_s;

  assign bj_taken_s  = BjBus[TAKEN_BIT];
  assign bj_target_s = {BjBus[BJ_TARGET_LSB+2 +: BITS-2], 2'b00};
  assign pc_inc_s    = pc_r + BITS'(INST_BYTES);
  assign ImemReq     = req_r;
  assign ImemAddr    = pc_r;

  // State, PC, latched redirect target and the request flag.
  always_ff @(posedge Clk) begin
    if (!Rstn) begin
      state_r <= IDLE;
      pc_r    <= RESET_PC;
      tgt_r   <= '0;
      req_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      pc_r    <= pc_next_s;
      tgt_r   <= tgt_next_s;
      req_r   <= req_next_s;
    end
  end

  // Next-state selection; a redirect beats a decode handshake in WAIT.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:  state_next_s = FETCH;
      FETCH: begin
        if (ImemAck) begin
          state_next_s = bj_taken_s ? FETCH : WAIT;
        end else if (bj_taken_s) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = FETCH;
        end
      end
      WAIT: begin
        if (bj_taken_s || (DecValid && DecReady)) begin
          state_next_s = FETCH;
        end else begin
          state_next_s = WAIT;
        end
      end
      DRAIN: begin
        if (ImemAck) begin
          state_next_s = FETCH;
        end else begin
          state_next_s = DRAIN;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Datapath controls: PC/target updates and output-register strobes.
  always_comb begin
    pc_next_s  = pc_r;
    tgt_next_s = tgt_r;
    load_s     = 1'b0;
    flush_s    = 1'b0;
    consume_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bj_taken_s) begin
          flush_s   = 1'b1;
          pc_next_s = bj_target_s;
        end else begin
          pc_next_s = pc_r;
        end
      end
      FETCH: begin
        if (ImemAck && bj_taken_s) begin
          flush_s   = 1'b1;
          pc_next_s = bj_target_s;
        end else if (ImemAck) begin
          load_s    = 1'b1;
          pc_next_s = pc_inc_s;
        end else if (bj_taken_s) begin
          flush_s    = 1'b1;
          tgt_next_s = bj_target_s;
        end else begin
          pc_next_s = pc_r;
        end
      end
      WAIT: begin
        if (bj_taken_s) begin
          flush_s   = 1'b1;
          pc_next_s = bj_target_s;
        end else if (DecValid && DecReady) begin
          consume_s = 1'b1;
        end else begin
          pc_next_s = pc_r;
        end
      end
      DRAIN: begin
        // Address stays on the bus until the in-flight word is acked and dropped.
        if (bj_taken_s) begin
          flush_s    = 1'b1;
          tgt_next_s = bj_target_s;
        end else begin
          tgt_next_s = tgt_r;
        end
        if (ImemAck) begin
          pc_next_s = bj_taken_s ? bj_target_s : tgt_r;
        end else begin
          pc_next_s = pc_r;
        end
      end
      default: begin
        pc_next_s = pc_r;
      end
    endcase
  end

  assign req_next_s = (state_next_s == FETCH) || (state_next_s == DRAIN);

  fetch_out_reg #(
    .BITS(BITS)
  ) u_out (
    .clk     (Clk),
    .rstn    (Rstn),
    .load    (load_s),
    .flush   (flush_s),
    .consume (consume_s),
    .pc_in   (pc_r),
    .inst_in (ImemData),
    .valid   (DecValid),
    .pc      (DecPC),
    .inst    (DecInst)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch with a small latency-programmable
// instruction memory; a second instance checks the PC wrap at the top of memory.
module tb_inst_fetch;

  logic        Clk = 1'b0;
  logic        Rstn;
  logic [32:0] BjBus;
  logic        ImemAck;
  logic [31:0] ImemData;
  logic        DecReady;
  logic        ImemReq, DecValid;
  logic [31:0] ImemAddr, DecPC, DecInst;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_pc, w_inst;

  int mem_lat;
  int wait_cnt;
  logic stray_ack;
  int chk_cnt;
  int pass_cnt;

  always #5 Clk = ~Clk;

  assign ImemAck  = stray_ack || (ImemReq === 1'b1 && wait_cnt >= mem_lat);
  assign ImemData = ImemAddr ^ 32'hC0DE_0000;

  always @(posedge Clk) begin
    if (ImemReq !== 1'b1 || ImemAck) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  inst_fetch dut (
    .Clk(Clk), .Rstn(Rstn), .BjBus(BjBus),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemAck(ImemAck), .ImemData(ImemData),
    .DecValid(DecValid), .DecPC(DecPC), .DecInst(DecInst), .DecReady(DecReady)
  );

  inst_fetch #(.BITS(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .Clk(Clk), .Rstn(Rstn), .BjBus(BjBus),
    .ImemReq(w_req), .ImemAddr(w_addr), .ImemAck(ImemAck), .ImemData(ImemData),
    .DecValid(w_valid), .DecPC(w_pc), .DecInst(w_inst), .DecReady(DecReady)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic reset_dut(input int lat, input logic ready);
    Rstn = 1'b0; BjBus = '0; stray_ack = 1'b0; mem_lat = lat; DecReady = ready;
    tick();
    tick();
    Rstn = 1'b1;
  endtask

  task automatic test_reset();
    reset_dut(0, 1'b1);
    Rstn = 1'b0;
    tick();
    chk_cnt++; if (ImemReq !== 1'b0) $display("FAIL rst_req: got %b expected 0", ImemReq); else pass_cnt++;
    chk_cnt++; if (DecValid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", DecValid); else pass_cnt++;
    chk_cnt++; if ({DecPC, DecInst} !== 64'd0) $display("FAIL rst_dec: got %h/%h expected 0/0", DecPC, DecInst); else pass_cnt++;
    chk_cnt++; if (ImemAddr !== 32'h0) $display("FAIL rst_addr: got %h expected 00000000", ImemAddr); else pass_cnt++;
    chk_cnt++; if (w_addr !== 32'hFFFF_FFFC) $display("FAIL rst_addr_w: got %h expected fffffffc", w_addr); else pass_cnt++;
    Rstn = 1'b1;
    tick();
    chk_cnt++; if (ImemReq !== 1'b1) $display("FAIL idle_one_cycle: got req %b expected 1", ImemReq); else pass_cnt++;
  endtask

  task automatic test_throughput();
    logic [31:0] a;
    reset_dut(0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      a = 32'(k) * 32'd4;
      tick();
      chk_cnt++;
      if ({ImemReq, ImemAddr, DecValid} !== {1'b1, a, 1'b0})
        $display("FAIL tput_req%0d: got req %b addr %h valid %b expected 1 %h 0", k, ImemReq, ImemAddr, DecValid, a);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if ({DecValid, DecPC, DecInst, ImemReq} !== {1'b1, a, a ^ 32'hC0DE_0000, 1'b0})
        $display("FAIL tput_dec%0d: got v %b pc %h inst %h req %b expected 1 %h %h 0", k, DecValid, DecPC, DecInst, ImemReq, a, a ^ 32'hC0DE_0000);
      else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    reset_dut(0, 1'b0);
    tick();
    chk_cnt++; if (ImemAddr !== 32'h0) $display("FAIL stall_first_addr: got %h expected 00000000", ImemAddr); else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_cnt++;
      if ({DecValid, DecPC, DecInst, ImemReq} !== {1'b1, 32'h0, 32'hC0DE_0000, 1'b0})
        $display("FAIL stall_hold%0d: got v %b pc %h inst %h req %b expected 1 00000000 c0de0000 0", k, DecValid, DecPC, DecInst, ImemReq);
      else pass_cnt++;
    end
    DecReady = 1'b1;
    tick();
    chk_cnt++;
    if ({ImemReq, ImemAddr, DecValid} !== {1'b1, 32'h4, 1'b0})
      $display("FAIL stall_resume: got req %b addr %h valid %b expected 1 00000004 0", ImemReq, ImemAddr, DecValid);
    else pass_cnt++;
  endtask

  task automatic test_drain();
    reset_dut(3, 1'b1);
    tick();
    BjBus = {1'b1, 32'h0000_0103};
    tick();
    BjBus = '0;
    for (int k = 0; k < 3; k++) begin
      chk_cnt++;
      if ({ImemReq, ImemAddr, DecValid} !== {1'b1, 32'h0, 1'b0})
        $display("FAIL drain_hold%0d: got req %b addr %h valid %b expected 1 00000000 0", k, ImemReq, ImemAddr, DecValid);
      else pass_cnt++;
      tick();
    end
    chk_cnt++;
    if ({ImemReq, ImemAddr, DecValid} !== {1'b1, 32'h100, 1'b0})
      $display("FAIL drain_redirect: got req %b addr %h valid %b expected 1 00000100 0", ImemReq, ImemAddr, DecValid);
    else pass_cnt++;
    for (int k = 0; k < 12 && DecValid !== 1'b1; k++) tick();
    chk_cnt++;
    if ({DecValid, DecPC, DecInst} !== {1'b1, 32'h100, 32'hC0DE_0100})
      $display("FAIL drain_first_dec: got v %b pc %h inst %h expected 1 00000100 c0de0100", DecValid, DecPC, DecInst);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back_redirect();
    reset_dut(0, 1'b1);
    tick();
    BjBus = {1'b1, 32'h0000_0200};
    tick();
    BjBus = '0;
    chk_cnt++;
    if ({DecValid, ImemReq, ImemAddr} !== {1'b0, 1'b1, 32'h200})
      $display("FAIL coinc_ack: got valid %b req %b addr %h expected 0 1 00000200", DecValid, ImemReq, ImemAddr);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({DecValid, DecPC, DecInst} !== {1'b1, 32'h200, 32'hC0DE_0200})
      $display("FAIL coinc_load: got v %b pc %h inst %h expected 1 00000200 c0de0200", DecValid, DecPC, DecInst);
    else pass_cnt++;
    BjBus = {1'b1, 32'h0000_0302};
    tick();
    BjBus = '0;
    chk_cnt++;
    if ({DecValid, ImemReq, ImemAddr} !== {1'b0, 1'b1, 32'h300})
      $display("FAIL wait_redirect: got valid %b req %b addr %h expected 0 1 00000300", DecValid, ImemReq, ImemAddr);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    reset_dut(0, 1'b1);
    tick();
    chk_cnt++; if ({w_req, w_addr} !== {1'b1, 32'hFFFF_FFFC}) $display("FAIL wrap_first: got %b %h expected 1 fffffffc", w_req, w_addr); else pass_cnt++;
    tick();
    chk_cnt++; if ({w_valid, w_pc} !== {1'b1, 32'hFFFF_FFFC}) $display("FAIL wrap_dec: got %b %h expected 1 fffffffc", w_valid, w_pc); else pass_cnt++;
    tick();
    chk_cnt++; if ({w_req, w_addr} !== {1'b1, 32'h0}) $display("FAIL wrap_second: got %b %h expected 1 00000000", w_req, w_addr); else pass_cnt++;
  endtask

  task automatic test_reset_in_drain();
    reset_dut(3, 1'b1);
    tick();
    BjBus = {1'b1, 32'h0000_0040};
    tick();
    BjBus = '0;
    Rstn = 1'b0;
    tick();
    Rstn = 1'b1;
    stray_ack = 1'b1;
    chk_cnt++;
    if ({ImemReq, DecValid} !== 2'b00) $display("FAIL rd_reset: got req %b valid %b expected 0 0", ImemReq, DecValid); else pass_cnt++;
    tick();
    stray_ack = 1'b0;
    chk_cnt++;
    if ({DecValid, ImemReq, ImemAddr} !== {1'b0, 1'b1, 32'h0})
      $display("FAIL rd_stray_ack: got valid %b req %b addr %h expected 0 1 00000000", DecValid, ImemReq, ImemAddr);
    else pass_cnt++;
    mem_lat = 0;
    tick();
    chk_cnt++;
    if ({DecValid, DecPC, DecInst} !== {1'b1, 32'h0, 32'hC0DE_0000})
      $display("FAIL rd_first_dec: got v %b pc %h inst %h expected 1 00000000 c0de0000", DecValid, DecPC, DecInst);
    else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    chk_cnt = 0; pass_cnt = 0;
    Rstn = 1'b0; BjBus = '0; DecReady = 1'b1; stray_ack = 1'b0; mem_lat = 0;
    test_reset();
    test_throughput();
    test_stall();
    test_drain();
    test_back_to_back_redirect();
    test_wrap();
    test_reset_in_drain();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
